// File: rtl/holy_lite_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_if
//  Purpose  : 32-bit AXI-Lite bundle (AW, W, B, AR, R channels).
//  Modports : master - drives addresses, data, valids and response readies
//             slave  - drives address/data readies and responses
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/holy_lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : holy_lite_arbiter
//  Purpose  : Two-requester AXI-Lite arbiter with a single outstanding
//             transaction on the shared downstream bus.
//  Ports    : clk      - rising-edge clock
//             rst_n    - asynchronous active-low reset
//             s0, s1   - requester ports (axi_lite_if.slave)
//             m        - shared downstream bus (axi_lite_if.master)
//             grant    - one-hot owner of m (01 = s0, 10 = s1, 00 = none)
//             arb_busy - high whenever the FSM is not IDLE
//  Params   : FIXED_PRIORITY - 0 = round-robin, 1 = s0 wins contention
//  Revision : 1.0 - initial release
// ============================================================================
module holy_lite_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  axi_lite_if.slave   s0,
  axi_lite_if.slave   s1,
  axi_lite_if.master  m,
  output logic [1:0]  grant,
  output logic        arb_busy
);

  localparam logic [1:0] c_IDLE     = 2'b00;
  localparam logic [1:0] c_GRANT_RD = 2'b01;
  localparam logic [1:0] c_GRANT_WR = 2'b10;

  logic [1:0] r_state;
  logic       r_owner;     // 0 = s0, 1 = s1
  logic       r_rr_last;   // last port served; 1 = s1
  logic       r_aw_done;
  logic       r_w_done;
  logic       r_ar_done;

  logic w_req0, w_req1, w_win, w_win_aw;
  logic w_in_wr, w_in_rd, w_sel1;

  assign w_req0 = s0.awvalid | s0.arvalid;
  assign w_req1 = s1.awvalid | s1.arvalid;

  // s1 wins when it is the only requester, or under round-robin when s0
  // was served last.
  assign w_win    = w_req1 & (~w_req0 | ((FIXED_PRIORITY == 0) & ~r_rr_last));
  // Within the winning port a pending write beats a pending read.
  assign w_win_aw = w_win ? s1.awvalid : s0.awvalid;

  assign w_in_wr = (r_state == c_GRANT_WR);
  assign w_in_rd = (r_state == c_GRANT_RD);
  // Addr/data path follows the owner while busy, otherwise rests on s0.
  assign w_sel1  = (r_state != c_IDLE) & r_owner;

  assign arb_busy = (r_state != c_IDLE);
  assign grant    = (w_in_wr | w_in_rd) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

  // ---------------------------------------------------------------- to m
  assign m.awaddr  = w_sel1 ? s1.awaddr : s0.awaddr;
  assign m.wdata   = w_sel1 ? s1.wdata  : s0.wdata;
  assign m.wstrb   = w_sel1 ? s1.wstrb  : s0.wstrb;
  assign m.araddr  = w_sel1 ? s1.araddr : s0.araddr;

  // Valids are masked once their channel has handshaken so the owner may
  // hold them without creating a second beat downstream.
  assign m.awvalid = w_in_wr & ~r_aw_done & (w_sel1 ? s1.awvalid : s0.awvalid);
  assign m.wvalid  = w_in_wr & ~r_w_done  & (w_sel1 ? s1.wvalid  : s0.wvalid);
  assign m.bready  = w_in_wr & (w_sel1 ? s1.bready : s0.bready);
  assign m.arvalid = w_in_rd & ~r_ar_done & (w_sel1 ? s1.arvalid : s0.arvalid);
  assign m.rready  = w_in_rd & (w_sel1 ? s1.rready : s0.rready);

  // ------------------------------------------------------ back to owners
  assign s0.awready = w_in_wr & ~r_owner & ~r_aw_done & m.awready;
  assign s0.wready  = w_in_wr & ~r_owner & ~r_w_done  & m.wready;
  assign s0.bvalid  = w_in_wr & ~r_owner & m.bvalid;
  assign s0.bresp   = m.bresp;
  assign s0.arready = w_in_rd & ~r_owner & ~r_ar_done & m.arready;
  assign s0.rvalid  = w_in_rd & ~r_owner & m.rvalid;
  assign s0.rdata   = m.rdata;
  assign s0.rresp   = m.rresp;

  assign s1.awready = w_in_wr & r_owner & ~r_aw_done & m.awready;
  assign s1.wready  = w_in_wr & r_owner & ~r_w_done  & m.wready;
  assign s1.bvalid  = w_in_wr & r_owner & m.bvalid;
  assign s1.bresp   = m.bresp;
  assign s1.arready = w_in_rd & r_owner & ~r_ar_done & m.arready;
  assign s1.rvalid  = w_in_rd & r_owner & m.rvalid;
  assign s1.rdata   = m.rdata;
  assign s1.rresp   = m.rresp;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_ar_done <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_ar_done <= 1'b0;
          if (w_req0 | w_req1) begin
            r_owner <= w_win;
            r_state <= w_win_aw ? c_GRANT_WR : c_GRANT_RD;
          end
        end
        c_GRANT_WR: begin
          if (m.awvalid && m.awready) r_aw_done <= 1'b1;
          if (m.wvalid && m.wready)   r_w_done  <= 1'b1;
          if (m.bvalid && m.bready) begin
            r_state   <= c_IDLE;
            r_rr_last <= r_owner;
          end
        end
        c_GRANT_RD: begin
          if (m.arvalid && m.arready) r_ar_done <= 1'b1;
          if (m.rvalid && m.rready) begin
            r_state   <= c_IDLE;
            r_rr_last <= r_owner;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_holy_lite_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_holy_lite_arbiter
//  Purpose  : Directed self-checking bench for holy_lite_arbiter; the bench
//             plays both requesters and the downstream slave cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_holy_lite_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant, f_grant;
  logic       arb_busy, f_busy;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         aw_hs, w_hs;
  logic       hs;
  logic [1:0] exp_g;

  always #5 clk = ~clk;

  axi_lite_if s0_if();
  axi_lite_if s1_if();
  axi_lite_if m_if();
  axi_lite_if f_s0_if();
  axi_lite_if f_s1_if();
  axi_lite_if f_m_if();

  holy_lite_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .s0(s0_if), .s1(s1_if), .m(m_if),
    .grant(grant), .arb_busy(arb_busy)
  );

  holy_lite_arbiter #(.FIXED_PRIORITY(1)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .s0(f_s0_if), .s1(f_s1_if), .m(f_m_if),
    .grant(f_grant), .arb_busy(f_busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    s0_if.awaddr = '0; s0_if.awvalid = 0; s0_if.wdata = '0; s0_if.wstrb = '0;
    s0_if.wvalid = 0;  s0_if.bready = 0;  s0_if.araddr = '0; s0_if.arvalid = 0; s0_if.rready = 0;
    s1_if.awaddr = '0; s1_if.awvalid = 0; s1_if.wdata = '0; s1_if.wstrb = '0;
    s1_if.wvalid = 0;  s1_if.bready = 0;  s1_if.araddr = '0; s1_if.arvalid = 0; s1_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bresp = '0; m_if.bvalid = 0;
    m_if.arready = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 0;
    f_s0_if.awaddr = '0; f_s0_if.awvalid = 0; f_s0_if.wdata = '0; f_s0_if.wstrb = '0;
    f_s0_if.wvalid = 0;  f_s0_if.bready = 0;  f_s0_if.araddr = '0; f_s0_if.arvalid = 0; f_s0_if.rready = 0;
    f_s1_if.awaddr = '0; f_s1_if.awvalid = 0; f_s1_if.wdata = '0; f_s1_if.wstrb = '0;
    f_s1_if.wvalid = 0;  f_s1_if.bready = 0;  f_s1_if.araddr = '0; f_s1_if.arvalid = 0; f_s1_if.rready = 0;
    f_m_if.awready = 0; f_m_if.wready = 0; f_m_if.bresp = '0; f_m_if.bvalid = 0;
    f_m_if.arready = 0; f_m_if.rdata = '0; f_m_if.rresp = '0; f_m_if.rvalid = 0;
  endtask

  // Leaves the bench just before the first clock edge with rst_n high.
  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------- reset
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    s0_if.arvalid = 1; s0_if.rready = 1; m_if.arready = 1; m_if.rvalid = 1;
    repeat (2) @(posedge clk); #1;
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", grant); end
    n_tests++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", arb_busy); end
    n_tests++; if ({m_if.arvalid, m_if.rready, m_if.awvalid, m_if.wvalid, m_if.bready} !== 5'b0) begin
      n_fail++; $display("FAIL rst_m_valids: got %b want 00000", {m_if.arvalid, m_if.rready, m_if.awvalid, m_if.wvalid, m_if.bready}); end
    n_tests++; if ({s0_if.arready, s0_if.rvalid, s1_if.arready, s1_if.rvalid} !== 4'b0) begin
      n_fail++; $display("FAIL rst_slave_side: got %b want 0000", {s0_if.arready, s0_if.rvalid, s1_if.arready, s1_if.rvalid}); end
    @(negedge clk);
    m_if.arready = 0; m_if.rvalid = 0;
    rst_n = 1'b1; #1;
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_release_grant: got %b want 00", grant); end
    nxt(); smp();
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rst_first_grant: got %b want 01", grant); end
  endtask

  // ------------------------------------------------------- single read
  task automatic test_single_read();
    apply_reset();
    nxt(); s1_if.arvalid = 1; s1_if.araddr = 32'h0000_1004; s1_if.rready = 1;
    smp();
    n_tests++; if (grant !== 2'b00 || m_if.arvalid !== 1'b0 || s1_if.arready !== 1'b0) begin
      n_fail++; $display("FAIL rd_c0_idle: got grant=%b arvalid=%b arready=%b want 00/0/0", grant, m_if.arvalid, s1_if.arready); end
    nxt(); smp();
    n_tests++; if (grant !== 2'b10 || arb_busy !== 1'b1) begin
      n_fail++; $display("FAIL rd_c1_grant: got grant=%b busy=%b want 10/1", grant, arb_busy); end
    n_tests++; if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h0000_1004) begin
      n_fail++; $display("FAIL rd_c1_ar: got arvalid=%b araddr=%h want 1/00001004", m_if.arvalid, m_if.araddr); end
    nxt(); m_if.arready = 1; smp();
    n_tests++; if (s1_if.arready !== 1'b1 || s0_if.arready !== 1'b0) begin
      n_fail++; $display("FAIL rd_c2_arready: got s1=%b s0=%b want 1/0", s1_if.arready, s0_if.arready); end
    nxt(); m_if.arready = 0; smp();
    n_tests++; if (m_if.arvalid !== 1'b0 || grant !== 2'b10) begin
      n_fail++; $display("FAIL rd_c3_ar_gated: got arvalid=%b grant=%b want 0/10", m_if.arvalid, grant); end
    nxt(); m_if.rvalid = 1; m_if.rdata = 32'hDEAD_BEEF; m_if.rresp = 2'b00; smp();
    n_tests++; if (s1_if.rvalid !== 1'b1 || s1_if.rdata !== 32'hDEAD_BEEF || s0_if.rvalid !== 1'b0 || m_if.rready !== 1'b1) begin
      n_fail++; $display("FAIL rd_c4_rdata: got s1.rvalid=%b rdata=%h s0.rvalid=%b rready=%b want 1/deadbeef/0/1",
                         s1_if.rvalid, s1_if.rdata, s0_if.rvalid, m_if.rready); end
    nxt(); m_if.rvalid = 0; s1_if.arvalid = 0; s1_if.rready = 0; smp();
    n_tests++; if (grant !== 2'b00 || arb_busy !== 1'b0) begin
      n_fail++; $display("FAIL rd_c5_idle: got grant=%b busy=%b want 00/0", grant, arb_busy); end
  endtask

  // ------------------------------------------- round-robin contention
  task automatic test_rr_contention();
    apply_reset();
    nxt();
    s0_if.arvalid = 1; s0_if.rready = 1; s1_if.arvalid = 1; s1_if.rready = 1; m_if.arready = 1;
    for (int i = 0; i < 12; i++) begin
      smp();
      exp_g = (i % 3 == 0) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
      n_tests++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_g); end
      hs = m_if.arvalid & m_if.arready;
      nxt();
      m_if.rvalid = hs;
    end
  endtask

  // ------------------------------------------------ fixed priority
  task automatic test_fixed_priority();
    apply_reset();
    nxt();
    f_s0_if.arvalid = 1; f_s0_if.rready = 1; f_s1_if.arvalid = 1; f_s1_if.rready = 1; f_m_if.arready = 1;
    for (int i = 0; i < 12; i++) begin
      smp();
      exp_g = (i % 3 == 0) ? 2'b00 : 2'b01;
      n_tests++; if (f_grant !== exp_g) begin n_fail++; $display("FAIL fp_grant[%0d]: got %b want %b", i, f_grant, exp_g); end
      n_tests++; if (f_s1_if.arready !== 1'b0 || f_s1_if.rvalid !== 1'b0) begin
        n_fail++; $display("FAIL fp_s1_starved[%0d]: got arready=%b rvalid=%b want 0/0", i, f_s1_if.arready, f_s1_if.rvalid); end
      hs = f_m_if.arvalid & f_m_if.arready;
      nxt();
      f_m_if.rvalid = hs;
    end
  endtask

  // ------------------------------------------------ write, W before AW
  task automatic test_write_w_first();
    apply_reset();
    aw_hs = 0; w_hs = 0;
    nxt();
    s0_if.awaddr = 32'h10; s0_if.awvalid = 1; s0_if.wdata = 32'h1234_5678; s0_if.wstrb = 4'b0011;
    s0_if.wvalid = 1; s0_if.bready = 1;
    smp();
    n_tests++; if (grant !== 2'b00 || m_if.wvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_c0_idle: got grant=%b wvalid=%b want 00/0", grant, m_if.wvalid); end
    nxt(); m_if.wready = 1; smp();
    if (m_if.awvalid && m_if.awready) aw_hs++;
    if (m_if.wvalid && m_if.wready) w_hs++;
    n_tests++; if (grant !== 2'b01 || m_if.awvalid !== 1'b1 || m_if.wvalid !== 1'b1 || m_if.awaddr !== 32'h10) begin
      n_fail++; $display("FAIL wr_c1_grant: got grant=%b awvalid=%b wvalid=%b awaddr=%h want 01/1/1/00000010",
                         grant, m_if.awvalid, m_if.wvalid, m_if.awaddr); end
    n_tests++; if (m_if.wdata !== 32'h1234_5678 || m_if.wstrb !== 4'b0011) begin
      n_fail++; $display("FAIL wr_c1_wdata: got wdata=%h wstrb=%b want 12345678/0011", m_if.wdata, m_if.wstrb); end
    n_tests++; if (s0_if.wready !== 1'b1 || s0_if.awready !== 1'b0) begin
      n_fail++; $display("FAIL wr_c1_readies: got wready=%b awready=%b want 1/0", s0_if.wready, s0_if.awready); end
    nxt(); smp();
    if (m_if.awvalid && m_if.awready) aw_hs++;
    if (m_if.wvalid && m_if.wready) w_hs++;
    n_tests++; if (m_if.wvalid !== 1'b0 || s0_if.wready !== 1'b0 || m_if.awvalid !== 1'b1) begin
      n_fail++; $display("FAIL wr_c2_w_gated: got wvalid=%b wready=%b awvalid=%b want 0/0/1", m_if.wvalid, s0_if.wready, m_if.awvalid); end
    nxt(); m_if.awready = 1; smp();
    if (m_if.awvalid && m_if.awready) aw_hs++;
    if (m_if.wvalid && m_if.wready) w_hs++;
    n_tests++; if (s0_if.awready !== 1'b1) begin n_fail++; $display("FAIL wr_c3_awready: got %b want 1", s0_if.awready); end
    nxt(); m_if.awready = 0; m_if.wready = 0; s0_if.awvalid = 0; s0_if.wvalid = 0;
    m_if.bvalid = 1; m_if.bresp = 2'b00; smp();
    n_tests++; if (s0_if.bvalid !== 1'b1 || s0_if.bresp !== 2'b00 || s1_if.bvalid !== 1'b0 || m_if.bready !== 1'b1) begin
      n_fail++; $display("FAIL wr_c4_bresp: got s0.bvalid=%b bresp=%b s1.bvalid=%b bready=%b want 1/00/0/1",
                         s0_if.bvalid, s0_if.bresp, s1_if.bvalid, m_if.bready); end
    nxt(); m_if.bvalid = 0; s0_if.bready = 0; smp();
    n_tests++; if (grant !== 2'b00 || arb_busy !== 1'b0) begin
      n_fail++; $display("FAIL wr_c5_idle: got grant=%b busy=%b want 00/0", grant, arb_busy); end
    n_tests++; if (aw_hs != 1 || w_hs != 1) begin
      n_fail++; $display("FAIL wr_single_beat: got aw_hs=%0d w_hs=%0d want 1/1", aw_hs, w_hs); end
  endtask

  // ---------------------------------------- simultaneous AW and AR on s0
  task automatic test_aw_ar_same_port();
    apply_reset();
    nxt();
    s0_if.awaddr = 32'h20; s0_if.awvalid = 1; s0_if.wdata = 32'h1; s0_if.wstrb = 4'hF; s0_if.wvalid = 1;
    s0_if.bready = 1; s0_if.araddr = 32'h30; s0_if.arvalid = 1; s0_if.rready = 1;
    smp();
    nxt(); m_if.awready = 1; m_if.wready = 1; smp();
    n_tests++; if (grant !== 2'b01 || m_if.awvalid !== 1'b1 || m_if.arvalid !== 1'b0) begin
      n_fail++; $display("FAIL awar_c1_write_first: got grant=%b awvalid=%b arvalid=%b want 01/1/0", grant, m_if.awvalid, m_if.arvalid); end
    nxt(); m_if.awready = 0; m_if.wready = 0; s0_if.awvalid = 0; s0_if.wvalid = 0;
    m_if.bvalid = 1; m_if.bresp = 2'b11; smp();
    n_tests++; if (s0_if.bvalid !== 1'b1 || s0_if.bresp !== 2'b11) begin
      n_fail++; $display("FAIL awar_c2_decerr: got bvalid=%b bresp=%b want 1/11", s0_if.bvalid, s0_if.bresp); end
    nxt(); m_if.bvalid = 0; s0_if.bready = 0; smp();
    n_tests++; if (grant !== 2'b00 || m_if.arvalid !== 1'b0) begin
      n_fail++; $display("FAIL awar_c3_idle: got grant=%b arvalid=%b want 00/0", grant, m_if.arvalid); end
    nxt(); m_if.arready = 1; smp();
    n_tests++; if (grant !== 2'b01 || m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h30) begin
      n_fail++; $display("FAIL awar_c4_read: got grant=%b arvalid=%b araddr=%h want 01/1/00000030", grant, m_if.arvalid, m_if.araddr); end
    nxt(); m_if.arready = 0; s0_if.arvalid = 0; m_if.rvalid = 1; m_if.rresp = 2'b10; m_if.rdata = 32'h0000_BAD0; smp();
    n_tests++; if (s0_if.rvalid !== 1'b1 || s0_if.rresp !== 2'b10 || s0_if.rdata !== 32'h0000_BAD0) begin
      n_fail++; $display("FAIL awar_c5_slverr: got rvalid=%b rresp=%b rdata=%h want 1/10/0000bad0", s0_if.rvalid, s0_if.rresp, s0_if.rdata); end
    nxt(); m_if.rvalid = 0; s0_if.rready = 0; smp();
    n_tests++; if (grant !== 2'b00 || arb_busy !== 1'b0) begin
      n_fail++; $display("FAIL awar_c6_idle: got grant=%b busy=%b want 00/0", grant, arb_busy); end
  endtask

  // ----------------------------------------- reset during a pending read
  task automatic test_reset_mid_read();
    apply_reset();
    nxt(); s1_if.arvalid = 1; s1_if.araddr = 32'h2000; s1_if.rready = 1; m_if.arready = 1;
    nxt(); smp();
    n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rstmid_grant: got %b want 10", grant); end
    nxt(); s1_if.arvalid = 0; m_if.arready = 0; smp();
    n_tests++; if (m_if.rready !== 1'b1 || arb_busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_waiting: got rready=%b busy=%b want 1/1", m_if.rready, arb_busy); end
    #2; rst_n = 1'b0; #1;
    n_tests++; if (grant !== 2'b00 || arb_busy !== 1'b0 || m_if.rready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async: got grant=%b busy=%b rready=%b want 00/0/0", grant, arb_busy, m_if.rready); end
    s1_if.rready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    nxt(); s1_if.arvalid = 1; s1_if.araddr = 32'h3000; s1_if.rready = 1; smp();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_req_idle: got %b want 00", grant); end
    nxt(); smp();
    n_tests++; if (grant !== 2'b10 || m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h3000) begin
      n_fail++; $display("FAIL rstmid_regrant: got grant=%b arvalid=%b araddr=%h want 10/1/00003000", grant, m_if.arvalid, m_if.araddr); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_contention();
    test_fixed_priority();
    test_write_w_first();
    test_aw_ar_same_port();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/holy_lite_arbiter.md
HOLY_LITE_ARBITER -- requirements
Module: holy_lite_arbiter

Interface
REQ-001 Parameter: FIXED_PRIORITY, default 0, meaning 0 = round-robin between ports, 1 = port s0 always wins contention.
REQ-002 Port: clk, input, 1, the single clock for the block; all logic is rising-edge.
REQ-003 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port: s0, axi_lite_if.slave, 32-bit addr/data, requester 0 (instruction-side uncached path).
REQ-005 Port: s1, axi_lite_if.slave, 32-bit addr/data, requester 1 (data-side uncached path).
REQ-006 Port: m, axi_lite_if.master, 32-bit addr/data, the shared downstream AXI-Lite bus.
REQ-007 Port: grant, output, 2, one-hot owner of m (01 = s0, 10 = s1, 00 = none).
REQ-008 Port: arb_busy, output, 1, high whenever a transaction is in flight (state is not IDLE).

Function
REQ-009 The FSM SHALL have three states: IDLE, GRANT_RD and GRANT_WR. State, owner, RR pointer and phase flags are registers.
REQ-010 A port requests when its awvalid or arvalid is high. Within one port, awvalid SHALL take precedence over arvalid.
REQ-011 In IDLE with exactly one port requesting, that port SHALL be granted on the next edge.
REQ-012 If both ports request and FIXED_PRIORITY=0, the port not served last SHALL win. The RR pointer resets to "s1 served last", so s0 wins first.
REQ-013 If both ports request and FIXED_PRIORITY=1, s0 SHALL win.
REQ-014 Arbitration latency SHALL be 1 cycle: request seen in IDLE, grant and m valid asserted the next cycle. No slave-side ready is asserted in IDLE.
REQ-015 In GRANT_WR, the owner's awaddr/awvalid, wdata/wstrb/wvalid and bready SHALL drive m. m.awready, m.wready, m.bvalid and m.bresp SHALL return to the owner.
REQ-016 In GRANT_WR, the AW and W handshakes SHALL complete in either order. Each channel's valid is gated to 0 after its handshake (aw_done, w_done flags).
REQ-017 GRANT_WR SHALL return to IDLE on the cycle m.bvalid && m.bready. The RR pointer is updated to the owner on that cycle.
REQ-018 In GRANT_RD, the owner's araddr/arvalid and rready SHALL drive m. m.arready, m.rvalid, m.rdata and m.rresp SHALL return to the owner.
REQ-019 In GRANT_RD, m.arvalid SHALL be gated to 0 after the AR handshake (ar_done).
REQ-020 GRANT_RD SHALL return to IDLE on m.rvalid && m.rready, with the RR pointer updated the same way.
REQ-021 At most one transaction SHALL be outstanding on m at any time.
REQ-022 The non-owner port SHALL see awready, wready, arready, bvalid and rvalid all at 0. Its valids are held pending, not dropped.
REQ-023 Response codes SHALL be passed unmodified. SLVERR/DECERR completes the transaction normally, with no retry.
REQ-024 If a port requests while its own transaction is terminating, it SHALL re-arbitrate only from IDLE. This gives a minimum 1 idle cycle between back-to-back transactions.
REQ-025 In IDLE, all m valid and ready outputs SHALL be 0. Addr/data outputs SHALL be s0's values (don't-care).
REQ-026 Entering a GRANT state with an unexpected state encoding SHALL force IDLE on the next edge.

Reset
REQ-027 On rst_n low, the block SHALL immediately (asynchronously) enter IDLE and clear all phase flags. grant=00, arb_busy=0, RR pointer = s1-last.
REQ-028 All m valids and all slave-side readies/valids SHALL be 0 during reset.
REQ-029 Reset mid-transaction SHALL abandon the transaction; the downstream slave is reset by the same rst_n.
REQ-030 The first grant after rst_n deasserts SHALL occur no earlier than the first clk edge with rst_n high.

Verification
REQ-031 Single read: s1 AR 0x0000_1004, slave arready at cycle 2 and rvalid with 0xDEADBEEF at cycle 4. Required: grant=10 from cycle 1, s1.rdata=0xDEADBEEF, then IDLE, then grant=00.
REQ-032 Contention, RR: s0 and s1 both issue reads continuously. Required: grants alternate s0,s1,s0,s1, with 1 IDLE cycle between each.
REQ-033 FIXED_PRIORITY=1 with both requesting continuously. Required: s0 is granted every time and s1 is starved.
REQ-034 Write with W before AW: s0 write 0x10=0x12345678 with wstrb=4'b0011, slave wready at cycle 1 and awready at cycle 3. Required: wvalid is gated after its handshake, a single write completes, and bresp=00 reaches s0 only.
REQ-035 Simultaneous aw and ar on s0 while s1 is idle. Required: the write is served first, then the read is granted after IDLE.
REQ-036 rst_n asserted low while GRANT_RD is waiting for rvalid. Required: same-cycle grant=00, arb_busy=0, m.rready=0, and a new s1 request after release is granted normally.
